// File: rtl/door_pkg.sv
// Shared types and constants for the door command/trajectory path.
package door_pkg;

    localparam int unsigned POS_W   = 17;
    localparam int unsigned WIDTH_W = 18;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_FRAME_CYCLES    = 1_000_000;
    localparam int unsigned DEF_MIN_WIDTH       = 100_000;
    localparam int unsigned DEF_SPAN            = 100_000;
    localparam int unsigned DEF_STEP            = 500;
    localparam int unsigned DEF_HOLD_FRAMES     = 500;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } door_state_t;

    function automatic logic is_moving(input door_state_t s);
        return (s == ST_OPENING) || (s == ST_CLOSING);
    endfunction

endpackage

// File: rtl/door_cmd_ramp_if.sv
// Button inputs and servo-command outputs of the door ramp stage.
interface door_cmd_ramp_if;
    import door_pkg::*;

    logic               btnL;
    logic               btnR;
    logic               frame_start;
    logic [WIDTH_W-1:0] width;
    door_state_t        state;
    logic               busy;
    logic               led;

    modport master (output btnL, btnR, input frame_start, width, state, busy, led);
    modport slave  (input btnL, btnR, output frame_start, width, state, busy, led);

endinterface

// File: rtl/door_cmd_ramp_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, one-cycle press pulse.
module btn_debounce
    import door_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int unsigned       CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_settle;

    // Synchronised input has disagreed with the debounced level long enough.
    assign w_settle = (r_sync2 != r_level) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_press <= w_settle && r_sync2;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_settle) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/door_cmd_ramp.sv
// Door command FSM, frame timer and position ramp driving the servo pulse width.
// Optional auto-close after an open dwell is enabled by defining DOOR_AUTO_CLOSE_EN.
module door_cmd_ramp
    import door_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned FRAME_CYCLES    = DEF_FRAME_CYCLES,
    parameter int unsigned MIN_WIDTH       = DEF_MIN_WIDTH,
    parameter int unsigned SPAN            = DEF_SPAN,
    parameter int unsigned STEP            = DEF_STEP,
    parameter int unsigned HOLD_FRAMES     = DEF_HOLD_FRAMES
) (
    input  logic           clk,
    input  logic           rst_n,
    door_cmd_ramp_if.slave door
);
    localparam int unsigned         FRAME_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [FRAME_W-1:0]  FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [POS_W-1:0]    POS_SPAN   = POS_W'(SPAN);
    localparam logic [POS_W-1:0]    POS_STEP   = POS_W'(STEP);
    localparam logic [WIDTH_W-1:0]  WID_SPAN   = WIDTH_W'(SPAN);
    localparam logic [WIDTH_W-1:0]  WID_STEP   = WIDTH_W'(STEP);
    localparam logic [WIDTH_W-1:0]  WID_MIN    = WIDTH_W'(MIN_WIDTH);

    if (STEP == 0 || STEP > SPAN || SPAN >= (32'd1 << POS_W) || HOLD_FRAMES == 0) begin : g_bad_cfg
        $error("door_cmd_ramp: need 0 < STEP <= SPAN < 2**POS_W and HOLD_FRAMES > 0");
    end

    logic               w_press_l;
    logic               w_press_r;
    logic               w_open_cmd;
    logic               w_close_cmd;
    logic               w_tick;
    door_state_t        r_state;
    door_state_t        w_state_cmd;
    door_state_t        w_state_nxt;
    logic [POS_W-1:0]   r_pos;
    logic [POS_W-1:0]   w_pos_nxt;
    logic [WIDTH_W-1:0] w_sum;
    logic [WIDTH_W-1:0] r_width;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_frame_start;
    logic               r_busy;
    logic               r_led;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (door.btnL),
        .o_press (w_press_l)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (door.btnR),
        .o_press (w_press_r)
    );

    // Conflicting presses in one cycle cancel each other.
    assign w_open_cmd  = w_press_l & ~w_press_r;
    assign w_close_cmd = w_press_r & ~w_press_l;
    assign w_tick      = (r_frame_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_tick;
            r_frame_cnt   <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + FRAME_W'(1);
        end
    end

`ifdef DOOR_AUTO_CLOSE_EN
    localparam int unsigned        HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES);

    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`endif

    // Press transitions first, then the frame step acts on the resulting state.
    always_comb begin
        w_state_cmd = r_state;
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_sum       = {1'b0, r_pos} + WID_STEP;
`ifdef DOOR_AUTO_CLOSE_EN
        w_hold_nxt  = r_hold;
`endif
        case (r_state)
            ST_CLOSED:  if (w_open_cmd)  w_state_cmd = ST_OPENING;
            ST_OPENING: if (w_close_cmd) w_state_cmd = ST_CLOSING;
            ST_OPEN: begin
                if (w_close_cmd) w_state_cmd = ST_CLOSING;
`ifdef DOOR_AUTO_CLOSE_EN
                if (w_open_cmd)  w_hold_nxt  = '0;
`endif
            end
            ST_CLOSING: if (w_open_cmd)  w_state_cmd = ST_OPENING;
            default:    w_state_cmd = r_state;
        endcase
        w_state_nxt = w_state_cmd;

        if (w_tick) begin
            case (w_state_cmd)
                ST_OPENING: begin
                    if (w_sum >= WID_SPAN) begin
                        w_pos_nxt   = POS_SPAN;
                        w_state_nxt = ST_OPEN;
                    end else begin
                        w_pos_nxt = w_sum[POS_W-1:0];
                    end
                end
                ST_CLOSING: begin
                    if (r_pos <= POS_STEP) begin
                        w_pos_nxt   = '0;
                        w_state_nxt = ST_CLOSED;
                    end else begin
                        w_pos_nxt = r_pos - POS_STEP;
                    end
                end
`ifdef DOOR_AUTO_CLOSE_EN
                ST_OPEN: begin
                    w_hold_nxt = w_hold_nxt + HOLD_W'(1);
                    if (w_hold_nxt == HOLD_LAST) w_state_nxt = ST_CLOSING;
                end
`endif
                default: w_pos_nxt = r_pos;
            endcase
        end

`ifdef DOOR_AUTO_CLOSE_EN
        if (w_state_nxt != ST_OPEN) w_hold_nxt = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLOSED;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    // Width only moves on the edge that raises frame_start, except at reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_width <= WID_MIN;
            r_busy  <= 1'b0;
            r_led   <= 1'b0;
        end else begin
            if (w_tick) r_width <= WID_MIN + {1'b0, w_pos_nxt};
            r_busy <= is_moving(w_state_nxt);
            r_led  <= (w_state_nxt == ST_OPEN);
        end
    end

    assign door.frame_start = r_frame_start;
    assign door.width       = r_width;
    assign door.state       = r_state;
    assign door.busy        = r_busy;
    assign door.led         = r_led;

endmodule

// File: tb/tb_door_cmd_ramp.sv
// Self-checking bench for door_cmd_ramp: directed vector table, corner sequences and a random run
// against a frame/window-level reference model. Honours DOOR_AUTO_CLOSE_EN when defined.
module tb_door_cmd_ramp;

    localparam int DEB  = 4;
    localparam int FRM  = 20;
    localparam int MINW = 100000;
    localparam int SPN  = 2000;
    localparam int STP  = 500;
    localparam int HLD  = 3;
    localparam int HIST = 1024;

    localparam int S_CLOSED  = 0;
    localparam int S_OPENING = 1;
    localparam int S_OPEN    = 2;
    localparam int S_CLOSING = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    door_cmd_ramp_if door ();

    door_cmd_ramp #(
        .DEBOUNCE_CYCLES (DEB),
        .FRAME_CYCLES    (FRM),
        .MIN_WIDTH       (MINW),
        .SPAN            (SPN),
        .STEP            (STP),
        .HOLD_FRAMES     (HLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .door  (door)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_e = 10;
    int m_n = 0;
    bit m_raw  [2][HIST];
    bit m_sync [2][HIST];
    bit m_lvl  [2];
    bit m_pend [2];
    int m_last [2];
    int m_st   = S_CLOSED;
    int m_pos  = 0;
    int m_hold = 0;
    bit m_fs   = 1'b0;

    task automatic model_step();
        bit cur [2];
        bit pl, pr, tick, flip;
        int ix;
        m_e++;
        ix = m_e % HIST;
        cur[0] = door.btnL;
        cur[1] = door.btnR;
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                m_raw[b][ix]  = 1'b0;
                m_sync[b][ix] = 1'b0;
                m_lvl[b]      = 1'b0;
                m_pend[b]     = 1'b0;
                m_last[b]     = m_e;
            end
            m_st = S_CLOSED; m_pos = 0; m_hold = 0; m_n = 0; m_fs = 1'b0;
        end else begin
            pl = m_pend[0];
            pr = m_pend[1];
            for (int b = 0; b < 2; b++) begin
                m_raw[b][ix]  = cur[b];
                m_sync[b][ix] = m_raw[b][(m_e - 2) % HIST];
                // new level accepted once the last DEB synced samples since the previous change all disagree
                flip = (m_e - m_last[b]) >= DEB;
                for (int j = 0; j < DEB; j++)
                    if (m_sync[b][(m_e - j) % HIST] == m_lvl[b]) flip = 1'b0;
                m_pend[b] = 1'b0;
                if (flip) begin
                    m_lvl[b]  = ~m_lvl[b];
                    m_last[b] = m_e;
                    m_pend[b] = m_lvl[b];
                end
            end
            tick = ((m_n % FRM) == 0);
            m_n++;
            if (pl && !pr) begin
                if (m_st == S_CLOSED || m_st == S_CLOSING) m_st = S_OPENING;
                else if (m_st == S_OPEN) m_hold = 0;
            end else if (pr && !pl) begin
                if (m_st == S_OPEN || m_st == S_OPENING) m_st = S_CLOSING;
            end
            if (tick) begin
                if (m_st == S_OPENING) begin
                    m_pos = (m_pos + STP > SPN) ? SPN : m_pos + STP;
                    if (m_pos == SPN) m_st = S_OPEN;
                end else if (m_st == S_CLOSING) begin
                    m_pos = (m_pos > STP) ? m_pos - STP : 0;
                    if (m_pos == 0) m_st = S_CLOSED;
                end
`ifdef DOOR_AUTO_CLOSE_EN
                else if (m_st == S_OPEN) begin
                    m_hold++;
                    if (m_hold == HLD) m_st = S_CLOSING;
                end
`endif
            end
            if (m_st != S_OPEN) m_hold = 0;
            m_fs = tick;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit bl;
        bit br;
        int cyc;
        int st;
        int wd;
        bit fs;
        bit ld;
        bit bs;
    } vec_t;

    vec_t vecs [17];

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRM + 5; i++) begin
            @(negedge clk);
            if (door.frame_start) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int run_left;
        door.btnL = 1'b0;
        door.btnR = 1'b0;

        vecs[0]  = '{1, 0,  1, S_CLOSED,  100000, 1, 0, 0};
        vecs[1]  = '{1, 0,  9, S_OPENING, 100000, 0, 0, 1};
        vecs[2]  = '{0, 0, 11, S_OPENING, 100500, 1, 0, 1};
        vecs[3]  = '{0, 0, 20, S_OPENING, 101000, 1, 0, 1};
        vecs[4]  = '{0, 0, 20, S_OPENING, 101500, 1, 0, 1};
        vecs[5]  = '{0, 0, 20, S_OPEN,    102000, 1, 1, 0};
        vecs[6]  = '{0, 1, 10, S_CLOSING, 102000, 0, 0, 1};
        vecs[7]  = '{0, 0, 10, S_CLOSING, 101500, 1, 0, 1};
        vecs[8]  = '{0, 0, 20, S_CLOSING, 101000, 1, 0, 1};
        vecs[9]  = '{1, 0, 10, S_OPENING, 101000, 0, 0, 1};
        vecs[10] = '{0, 0, 10, S_OPENING, 101500, 1, 0, 1};
        vecs[11] = '{0, 1, 10, S_CLOSING, 101500, 0, 0, 1};
        vecs[12] = '{0, 0, 10, S_CLOSING, 101000, 1, 0, 1};
        vecs[13] = '{0, 0, 20, S_CLOSING, 100500, 1, 0, 1};
        vecs[14] = '{0, 0, 20, S_CLOSED,  100000, 1, 0, 0};
        vecs[15] = '{1, 1, 10, S_CLOSED,  100000, 0, 0, 0};
        vecs[16] = '{0, 0, 10, S_CLOSED,  100000, 1, 0, 0};

        // reset state
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_state", int'(door.state), S_CLOSED);
        check("reset_width", int'(door.width), MINW);
        check("reset_led",   int'(door.led), 0);
        check("reset_busy",  int'(door.busy), 0);
        check("reset_fs",    int'(door.frame_start), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            door.btnL = vecs[i].bl;
            door.btnR = vecs[i].br;
            repeat (vecs[i].cyc) @(negedge clk);
            check($sformatf("vec%0d_state", i), int'(door.state), vecs[i].st);
            check($sformatf("vec%0d_width", i), int'(door.width), vecs[i].wd);
            check($sformatf("vec%0d_fs", i),    int'(door.frame_start), int'(vecs[i].fs));
            check($sformatf("vec%0d_led", i),   int'(door.led), int'(vecs[i].ld));
            check($sformatf("vec%0d_busy", i),  int'(door.busy), int'(vecs[i].bs));
        end

        // bounce rejection
        for (int i = 0; i < 10; i++) begin
            door.btnL = ~door.btnL;
            repeat (2) @(negedge clk);
        end
        door.btnL = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_state", int'(door.state), S_CLOSED);
        check("bounce_width", int'(door.width), MINW);

        // reset in the middle of a ramp
        door.btnL = 1'b1;
        repeat (10) @(negedge clk);
        door.btnL = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (int'(door.width) > MINW) ok = 1'b1;
        end
        check("midramp_reached", int'(ok), 1);
        check("midramp_opening", int'(door.state), S_OPENING);
        rst_n = 1'b0;
        @(negedge clk);
        check("midramp_rst_width", int'(door.width), MINW);
        check("midramp_rst_state", int'(door.state), S_CLOSED);
        check("midramp_rst_busy",  int'(door.busy), 0);
        rst_n = 1'b1;

        // open dwell: auto-close or hold
        door.btnL = 1'b1;
        repeat (10) @(negedge clk);
        door.btnL = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (int'(door.state) == S_OPEN) ok = 1'b1;
        end
        check("dwell_reached_open", int'(ok), 1);
        check("dwell_entry_fs", int'(door.frame_start), 1);
        check("dwell_entry_led", int'(door.led), 1);
`ifdef DOOR_AUTO_CLOSE_EN
        for (int k = 1; k <= 3; k++) begin
            wait_fs(ok);
            check("dwell_fs_seen", int'(ok), 1);
            check($sformatf("autoclose_frame%0d", k), int'(door.state), (k < 3) ? S_OPEN : S_CLOSING);
        end
`else
        for (int k = 1; k <= 10; k++) begin
            wait_fs(ok);
            check("dwell_fs_seen", int'(ok), 1);
            check($sformatf("hold_open_frame%0d", k), int'(door.state), S_OPEN);
        end
`endif

        // randomized run against the reference model
        rst_n = 1'b0;
        door.btnL = 1'b0;
        door.btnR = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            check("rnd_state", int'(door.state), m_st);
            check("rnd_width", int'(door.width), MINW + m_pos);
            check("rnd_fs",    int'(door.frame_start), int'(m_fs));
            check("rnd_busy",  int'(door.busy), (m_st == S_OPENING || m_st == S_CLOSING) ? 1 : 0);
            check("rnd_led",   int'(door.led), (m_st == S_OPEN) ? 1 : 0);
            rst_n = ($urandom_range(0, 999) != 0);
            if (run_left == 0) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: begin door.btnL = 1'b1; door.btnR = 1'b0; end
                    3, 4, 5: begin door.btnL = 1'b0; door.btnR = 1'b1; end
                    6:       begin door.btnL = 1'b1; door.btnR = 1'b1; end
                    default: begin door.btnL = 1'b0; door.btnR = 1'b0; end
                endcase
                run_left = $urandom_range(1, 14);
            end else begin
                run_left--;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
